selector_seq: RTL and testbench
===============================

SELECTOR_SEQ -- requirements
Module: selector_seq

Interface
REQ-001 Parameter DWELL_W, default 4: width of the per-step dwell count.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cfg_we  input  1  write strobe for the mode table.
REQ-005 cfg_addr  input  2  mode-table entry index, 0..3.
REQ-006 cfg_sel  input  2  mode code written to entry cfg_addr.
REQ-007 dwell  input  DWELL_W  cycles to wait after each sel change before sampling.
REQ-008 start  input  1  single-cycle request to run one 4-step sequence.
REQ-009 stop  input  1  abort request.
REQ-010 q_in  input  1  Q output of the driven selector.
REQ-011 nq_in  input  1  NQ output of the driven selector.
REQ-012 sel  output  2  mode select driven to the selector; registered.
REQ-013 busy  output  1  high while a sequence is running.
REQ-014 done  output  1  one-cycle pulse when a sequence completes normally.
REQ-015 result  output  4  result[i] is the q_in sample taken at step i.
REQ-016 err  output  1  sticky flag: q_in equalled nq_in at some sample of the current or last run.

Function
REQ-017 The block SHALL hold a 4-entry x 2-bit mode table; cfg_we=1 in IDLE writes cfg_sel to entry cfg_addr at the clock edge.
REQ-018 cfg_we SHALL be ignored in RUN and DONE; the table is not modified.
REQ-019 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-020 IDLE with start=1 and stop=0 SHALL, at that edge:
- go to RUN;
- set step=0 and cnt=0;
- set sel=table[0];
- latch dwell into dwell_q;
- clear result and err.
REQ-021 IDLE with start=1 and stop=1 SHALL remain in IDLE with no state change (stop wins).
REQ-022 In RUN the block SHALL increment cnt each cycle while cnt != dwell_q.
REQ-023 In RUN, on the cycle where cnt == dwell_q, the block SHALL:
- write result[step] <= q_in;
- set err <= err | (q_in == nq_in).
REQ-024 On that sample cycle with step < 3, the block SHALL set step <= step+1, sel <= table[step+1] and cnt <= 0.
REQ-025 On that sample cycle with step == 3, the block SHALL go to DONE with sel unchanged.
REQ-026 Timing: each step SHALL occupy dwell_q+1 RUN cycles; dwell_q=0 samples on the first RUN cycle of each step.
REQ-027 A full sequence SHALL last 4*(dwell_q+1) RUN cycles; busy=1 exactly in RUN.
REQ-028 DONE SHALL last one cycle with done=1 and then return to IDLE.
REQ-029 done SHALL be 0 in every other state.
REQ-030 stop=1 in RUN SHALL return the FSM to IDLE at the next edge, overriding a same-cycle sample.
REQ-031 On such an abort:
- no sample is taken on the stop cycle;
- result bits sampled earlier and err are retained;
- sel holds its value;
- done is not pulsed.
REQ-032 start SHALL be ignored in RUN and DONE.
REQ-033 dwell changes during RUN SHALL have no effect until the next start.
REQ-034 sel, busy and done SHALL be driven from registers, with no combinational path from inputs.
REQ-035 cnt SHALL be DWELL_W bits wide and SHALL never wrap, because it stops at dwell_q.

Reset
REQ-036 While rst_n=0 the block SHALL, asynchronously:
- put the FSM in IDLE with step=0, cnt=0 and dwell_q=0;
- drive sel=2'b00, busy=0, done=0, result=4'b0000, err=0;
- load table entries 0..3 with 2'b00, 2'b01, 2'b10, 2'b11.
REQ-037 Reset asserted mid-RUN SHALL abort immediately to the REQ-036 values; the first start after release SHALL run a full sequence.

Verification
REQ-038 Reset defaults: release reset, dwell=0, pulse start, drive a=1,b=0 through a behavioural selector model.
- sel sequence SHALL be 00,01,10,11, one cycle each;
- result SHALL be 4'b1001 (bit0=1, bit1=0, bit2=0, bit3=1);
- done SHALL pulse once, 4 cycles after start;
- err SHALL be 0.
REQ-039 Dwell: dwell=3, pulse start.
- each sel value SHALL be held 4 cycles;
- busy SHALL be high for 16 cycles;
- change dwell to 0 mid-run: step length SHALL stay 4 cycles.
REQ-040 Table reprogram: write table = {11,11,00,00} in IDLE, a=0, b=1, start.
- sel sequence SHALL be 00,00,11,11;
- result SHALL be 4'b1100.
- A cfg_we issued during RUN SHALL leave the table unchanged on the next run.
REQ-041 Abort: dwell=2, assert stop on the 5th RUN cycle.
- FSM SHALL be IDLE next cycle;
- done SHALL stay 0;
- result[0] SHALL be valid and result[3:1]=000;
- start with stop asserted together in IDLE SHALL stay IDLE.
REQ-042 Error and reset: tie nq_in=q_in, run with dwell=0.
- err SHALL be 1 after the first sample and remain 1;
- assert rst_n=0 mid-run: all outputs SHALL take the REQ-036 values with no clock edge.

Source files
------------

// File: rtl/selector_seq.sv
// selector_seq: steps a driven selector through a 4-entry mode table, dwelling before sampling q_in at each step.
module selector_seq #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [1:0]         cfg_sel,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               start,
    input  logic               stop,
    input  logic               q_in,
    input  logic               nq_in,
    output logic [1:0]         sel,
    output logic               busy,
    output logic               done,
    output logic [3:0]         result,
    output logic               err
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [1:0]         step;
    logic [1:0]         nxt;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_q;
    logic [1:0]         tbl [4];

    assign nxt = step + 2'd1;

    // Sequencer: table writes in IDLE, dwell/sample stepping in RUN, one-cycle done pulse in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            step    <= 2'd0;
            cnt     <= '0;
            dwell_q <= '0;
            sel     <= 2'b00;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= 4'b0000;
            err     <= 1'b0;
            tbl[0]  <= 2'b00;
            tbl[1]  <= 2'b01;
            tbl[2]  <= 2'b10;
            tbl[3]  <= 2'b11;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (cfg_we) tbl[cfg_addr] <= cfg_sel;
                    if (start && !stop) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        step    <= 2'd0;
                        cnt     <= '0;
                        sel     <= tbl[0];
                        dwell_q <= dwell;
                        result  <= 4'b0000;
                        err     <= 1'b0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt != dwell_q) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        result[step] <= q_in;
                        err          <= err | (q_in == nq_in);
                        if (step != 2'd3) begin
                            step <= nxt;
                            sel  <= tbl[nxt];
                            cnt  <= '0;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_selector_seq.sv
// tb_selector_seq: table-driven and directed checks of selector_seq against a behavioural selector.
module tb_selector_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = 2'd0;
    logic [1:0] cfg_sel = 2'd0;
    logic [3:0] dwell = 4'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       q_in, nq_in;
    logic [1:0] sel;
    logic       busy, done, err;
    logic [3:0] result;
    logic       a = 1'b0, b = 1'b0, tie = 1'b0;
    int         errors = 0;
    int         checks = 0;

    typedef struct packed {
        logic       prog;
        logic [7:0] tbl;
        logic [3:0] dwell;
        logic       a;
        logic       b;
        logic       tie;
        logic [3:0] exp_res;
        logic       exp_err;
    } vec_t;

    vec_t vecs [5];

    // Behavioural selector: 00 passes a, 01 passes b, 10 forces 0, 11 forces 1.
    assign q_in  = (sel == 2'b00) ? a : (sel == 2'b01) ? b : (sel == 2'b11);
    assign nq_in = tie ? q_in : ~q_in;

    always #5 clk = ~clk;

    selector_seq #(.DWELL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel),
        .dwell(dwell), .start(start), .stop(stop), .q_in(q_in), .nq_in(nq_in),
        .sel(sel), .busy(busy), .done(done), .result(result), .err(err)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic watch(output int nb, output int nd);
        int c;
        nb = 0;
        nd = 0;
        for (c = 0; c < 200 && (busy || done); c++) begin
            nb += int'(busy);
            nd += int'(done);
            tick();
        end
        chk("watch_timeout", int'(c < 200), 1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [7:0] t;
        logic [1:0] es;
        int nb, nd, done_at, sel_bad, err_bad, c, len;
        t = v.tbl;
        len = int'(v.dwell) + 1;
        if (v.prog) begin
            for (int i = 0; i < 4; i++) begin
                cfg_we = 1'b1;
                cfg_addr = 2'(i);
                cfg_sel = t[2*i +: 2];
                tick();
            end
            cfg_we = 1'b0;
        end
        a = v.a;
        b = v.b;
        tie = v.tie;
        dwell = v.dwell;
        pulse_start();
        nb = 0; nd = 0; done_at = 0; sel_bad = 0; err_bad = 0;
        for (c = 1; c < 200 && (busy || done); c++) begin
            if (busy) begin
                es = t[2*((nb/len) % 4) +: 2];
                if (sel !== es) sel_bad++;
                if (nb >= len && err !== v.exp_err) err_bad++;
                nb++;
            end
            if (done) begin
                nd++;
                done_at = c;
            end
            tick();
        end
        chk($sformatf("v%0d_timeout", idx), int'(c < 200), 1);
        chk($sformatf("v%0d_busy_cycles", idx), nb, 4*len);
        chk($sformatf("v%0d_done_count", idx), nd, 1);
        chk($sformatf("v%0d_done_latency", idx), done_at - 1, 4*len);
        chk($sformatf("v%0d_sel_seq_bad", idx), sel_bad, 0);
        chk($sformatf("v%0d_err_bad", idx), err_bad, 0);
        chk($sformatf("v%0d_result", idx), int'(result), int'(v.exp_res));
        chk($sformatf("v%0d_err", idx), int'(err), int'(v.exp_err));
    endtask

    initial begin
        int nb, nd;
        vecs[0] = '{1'b1, 8'hE4, 4'd0, 1'b1, 1'b0, 1'b0, 4'b1001, 1'b0};
        vecs[1] = '{1'b1, 8'hE4, 4'd3, 1'b1, 1'b0, 1'b0, 4'b1001, 1'b0};
        vecs[2] = '{1'b1, 8'hF0, 4'd0, 1'b0, 1'b1, 1'b0, 4'b1100, 1'b0};
        vecs[3] = '{1'b1, 8'hE4, 4'd1, 1'b0, 1'b1, 1'b0, 4'b1010, 1'b0};
        vecs[4] = '{1'b1, 8'hE4, 4'd0, 1'b1, 1'b0, 1'b1, 4'b1001, 1'b1};

        tick();
        tick();
        chk("rst_sel", int'(sel), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_err", int'(err), 0);
        rst_n = 1'b1;
        tick();

        // Defaults straight out of reset, no table programming.
        run_vec(100, '{1'b0, 8'hE4, 4'd0, 1'b1, 1'b0, 1'b0, 4'b1001, 1'b0});
        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Dwell change mid-run must not alter step length.
        dwell = 4'd3;
        pulse_start();
        dwell = 4'd0;
        watch(nb, nd);
        chk("dwell_change_busy", nb, 16);
        chk("dwell_change_done", nd, 1);

        // Table writes during RUN are ignored.
        dwell = 4'd1;
        pulse_start();
        cfg_we = 1'b1;
        cfg_addr = 2'd0;
        cfg_sel = 2'b11;
        tick();
        tick();
        cfg_we = 1'b0;
        watch(nb, nd);
        run_vec(101, '{1'b0, 8'hE4, 4'd0, 1'b1, 1'b0, 1'b0, 4'b1001, 1'b0});

        // Abort on the 5th RUN cycle with dwell=2.
        a = 1'b1; b = 1'b0; tie = 1'b0;
        dwell = 4'd2;
        pulse_start();
        for (int i = 0; i < 4; i++) tick();
        stop = 1'b1;
        tick();
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_result", int'(result), 1);
        chk("abort_sel", int'(sel), 1);
        chk("abort_err", int'(err), 0);
        stop = 1'b0;
        tick();
        chk("abort_done_late", int'(done), 0);
        chk("abort_busy_late", int'(busy), 0);

        // start together with stop in IDLE stays idle.
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        chk("startstop_busy", int'(busy), 0);
        chk("startstop_sel", int'(sel), 1);
        chk("startstop_result", int'(result), 1);
        tick();
        chk("startstop_busy_late", int'(busy), 0);

        // Sticky err, then asynchronous reset mid-run restores table and outputs.
        cfg_we = 1'b1;
        cfg_addr = 2'd0;
        cfg_sel = 2'b11;
        tick();
        cfg_we = 1'b0;
        tie = 1'b1;
        dwell = 4'd0;
        pulse_start();
        chk("tie_err_before", int'(err), 0);
        tick();
        chk("tie_err_first", int'(err), 1);
        tick();
        chk("tie_err_hold", int'(err), 1);
        chk("tie_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sel", int'(sel), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_result", int'(result), 0);
        chk("arst_err", int'(err), 0);
        #1 rst_n = 1'b1;
        tick();
        tie = 1'b0;
        run_vec(102, '{1'b0, 8'hE4, 4'd0, 1'b1, 1'b0, 1'b0, 4'b1001, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
